// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, width helpers and parity-sense constants
// (also intended for the parametrised transmitter).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int unsigned UART_MIN_DATA_BITS = 5;
  localparam int unsigned UART_MAX_DATA_BITS = 9;
  localparam int unsigned UART_BIT_CNT_W     = $clog2(UART_MAX_DATA_BITS + 1);

  localparam logic UART_PARITY_EVEN = 1'b0;
  localparam logic UART_PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// rx line conditioning: 2-flop synchroniser feeding a 3-sample history with majority vote.
// Everything resets to the idle (high) line level.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic sync_o,
  output logic maj_o
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign sync_o = sync_q[1];
  assign maj_o  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_receiver.sv
// Parametrised UART receiver with centre majority sampling and valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit per frame and drive parity_err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter logic        PARITY_ODD = UART_PARITY_EVEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = UART_BIT_CNT_W;
  localparam logic [CW-1:0] HALF_C = CW'(OVERSAMPLE / 2);

  uart_rx_state_t       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 f_bad_q, f_bad_d;
  logic                 deliver;
  logic                 sync_s, maj_s, tick_last;

  logic [DATA_BITS-1:0] out_q;
  logic                 valid_q, ferr_q, ovr_q;

  uart_rx_sync u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .rx_i   (in),
    .sync_o (sync_s),
    .maj_o  (maj_s)
  );

  assign tick_last = (cnt_q == '1);

`ifdef UART_RX_PARITY_EN
  logic p_bad_q, p_bad_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      f_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      f_bad_q <= f_bad_d;
`ifdef UART_RX_PARITY_EN
      p_bad_q <= p_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    f_bad_d = f_bad_q;
`ifdef UART_RX_PARITY_EN
    p_bad_d = p_bad_q;
`endif
    deliver = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && !sync_s) begin
          state_d = START;
          bit_d   = '0;
          f_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          p_bad_d = 1'b0;
`endif
        end
      end
      START: begin
        // Start-bit centre; a high majority here is a glitch, not a frame.
        if (cnt_q == HALF_C) begin
          cnt_d   = '0;
          state_d = maj_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_last) begin
          shift_d = {maj_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_last) begin
          p_bad_d = maj_s ^ (^shift_q) ^ PARITY_ODD;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_last) begin
          if (!maj_s) f_bad_d = 1'b1;
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            deliver = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      deliver = 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      // A held, unaccepted word wins: the newer frame is dropped and flagged.
      if (deliver) begin
        if (!valid_q || ready) begin
          out_q   <= shift_q;
          ferr_q  <= f_bad_d;
          valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_q  <= p_bad_q;
`endif
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      if (!en) ovr_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level expectation queue plus directed scenarios.
module tb_uart_receiver;

  localparam int D    = 8;
  localparam int OS   = 16;
  localparam int S    = 1;
  localparam int HALF = OS / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 3 + HALF + (D + P + S) * OS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         rx_in = 1'b1;
  logic         ready = 1'b1;
  logic [D-1:0] dout;
  logic         valid, busy, frame_err, parity_err, overrun;

  uart_receiver #(
    .DATA_BITS  (D),
    .OVERSAMPLE (OS),
    .STOP_BITS  (S),
    .PARITY_ODD (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in         (rx_in),
    .out        (dout),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Frame-level model: each expected word is due LAT edges after the first edge sampling the start bit.
  typedef struct {
    int           due;
    logic [D-1:0] d;
    logic         fe;
    logic         pe;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e;
  int           cyc = 0;
  int           last_start = 0;
  logic         m_valid = 1'b0, m_fe = 1'b0, m_pe = 1'b0, m_ovr = 1'b0;
  logic [D-1:0] m_out = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_valid = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ovr = 1'b0; m_out = '0;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (!m_valid || ready) begin
          m_out = e.d; m_fe = e.fe; m_pe = e.pe; m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      if (!en) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid", valid, m_valid);
      check("overrun", overrun, m_ovr);
      if (m_valid) begin
        check("out", dout, m_out);
        check("frame_err", frame_err, m_fe);
        check("parity_err", parity_err, m_pe);
      end
    end
  end

  task automatic send_frame(input logic [D-1:0] d, input bit stop_low, input bit par_wrong,
                            input int glitch_bit, input bit expect_it);
    exp_t x;
    logic v, par;
    int   nbits;
    @(negedge clk);
    last_start = cyc;
    par   = (^d) ^ par_wrong;
    nbits = 1 + D + P + S;
    if (expect_it) begin
      x.due = cyc + 1 + LAT; x.d = d; x.fe = stop_low; x.pe = par_wrong && (P == 1);
      exp_q.push_back(x);
    end
    for (int b = 0; b < nbits; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= D) v = d[b-1];
      else if (P == 1 && b == D + 1) v = par;
      else v = !stop_low;
      for (int t = 0; t < OS; t++) begin
        rx_in = (b >= 1 && b <= D && glitch_bit == b - 1 && t == HALF - 1) ? ~v : v;
        @(negedge clk);
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  seen;

    repeat (3) @(negedge clk);
    check("rst_out", dout, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    en  = 1'b1;
    idle(5);

    // Basic frame with absolute latency pinned by hand.
    fork
      send_frame(8'hA5, 0, 0, -1, 1);
      begin
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          if (valid) seen = 1;
        end
        check("basic_seen", seen, 1);
        lat = cyc - (last_start + 1);
`ifdef UART_RX_PARITY_EN
        check("basic_latency", lat, 171);
`else
        check("basic_latency", lat, 155);
`endif
        check("basic_out", dout, 8'hA5);
        check("basic_ferr", frame_err, 0);
        @(negedge clk);
        check("basic_pulse", valid, 0);
      end
    join
    idle(20);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h3C, 0, 1, -1, 1);
    idle(20);
`endif

    // Stop bit held low; the trailing low also causes a harmless false start.
    send_frame(8'h55, 1, 0, -1, 1);
    idle(40);

    // 4-tick glitch on idle line.
    @(negedge clk);
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(2);
    check("glitch_busy_hi", busy, 1);
    idle(30);
    check("glitch_busy_lo", busy, 0);

    // Single-tick inversion inside bit 2's sampling window.
    send_frame(8'h96, 0, 0, 2, 1);
    idle(10);

    // Overrun with back-to-back frames.
    ready = 1'b0;
    send_frame(8'h11, 0, 0, -1, 1);
    send_frame(8'h22, 0, 0, -1, 1);
    idle(10);
    check("ovr_out", dout, 8'h11);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", valid, 1);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_fall", valid, 0);
    en = 1'b0;
    @(negedge clk);
    check("ovr_cleared", overrun, 0);
    en = 1'b1;
    idle(10);

    // en dropped in the middle of data bit 4.
    fork
      send_frame(8'hC3, 0, 0, -1, 0);
      begin
        repeat ((1 + 4) * OS + HALF) @(negedge clk);
        check("abort_busy_before", busy, 1);
        en = 1'b0;
        idle(2);
        check("abort_busy", busy, 0);
      end
    join
    idle(5);
    en = 1'b1;
    idle(5);
    send_frame(8'hF0, 0, 0, -1, 1);
    idle(20);

    // Asynchronous reset mid-frame with a word held.
    ready = 1'b0;
    send_frame(8'h77, 0, 0, -1, 1);
    idle(10);
    check("hold_valid", valid, 1);
    check("hold_out", dout, 8'h77);
    fork
      send_frame(8'h5A, 0, 0, -1, 0);
      begin
        repeat (60) @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_out", dout, 0);
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        check("arst_ferr", frame_err, 0);
        check("arst_ovr", overrun, 0);
      end
    join
    idle(3);
    rst   = 1'b0;
    ready = 1'b1;
    idle(10);

    check("pending_frames", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Parametrised UART receive deserialiser, the configurable successor to the fixed 8N1 receiver. It sits on the rx pin behind the baud-rate divider and recovers frames of configurable data width, parity and stop-bit count. Each bit is majority-voted at its centre. Received words go out over a valid/ready handshake with per-word error flags and an overrun indication.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `OVERSAMPLE`, default 16: `clk` ticks per baud interval; must be a power of two and at least 8.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `PARITY_ODD`, default 0: parity sense, 0 = even, 1 = odd. Used only when `UART_RX_PARITY_EN` is defined.
- `clk`, in, 1: rx sampling clock at `OVERSAMPLE` × baud. One clock domain.
- `rst`, in, 1: reset, asynchronous and active-high.
- `en`, in, 1: receiver enable.
- `in`, in, 1: asynchronous rx line; idle level is high.
- `out`, out, `DATA_BITS`: received word, LSB received first.
- `valid`, out, 1: `out` and the error flags hold a word.
- `ready`, in, 1: consumer accepts the word.
- `busy`, out, 1: a frame is in progress (any state other than IDLE).
- `frame_err`, out, 1: stop bit sampled low. Qualified by `valid`.
- `parity_err`, out, 1: parity mismatch. Qualified by `valid`.
- `overrun`, out, 1: sticky; a completed frame was dropped.

## Operation
- **Input conditioning:** `in` passes through a 2-flop synchroniser into a 3-deep history shift register. The bit value is the majority of the 3 most recent synchronised samples.
- **Counter:** tick counter is `$clog2(OVERSAMPLE)` bits wide and wraps naturally. `HALF = OVERSAMPLE/2`.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - Synchronised sample low → clear counter, go to START.
  - `en` low → stay in IDLE.
- **START:**
  - At count `HALF`, majority low → clear counter, go to DATA. This is the start-bit centre.
  - At count `HALF`, majority high → false start; return to IDLE. No flag is set.
- **DATA:**
  - At each count `OVERSAMPLE-1`, shift the majority bit in at the MSB of the shift register (LSB-first reception).
  - After `DATA_BITS` samples → go to PARITY if parity is compiled in, otherwise STOP.
- **PARITY:** sample once, compare against the XOR of the data bits and `PARITY_ODD`. Mismatch latches an internal `p_bad` flag.
- **STOP:**
  - Sample `STOP_BITS` times.
  - Any low sample sets an internal `f_bad` flag.
  - After the last stop sample, deliver the word and return to IDLE immediately. The next start bit is accepted from the half-stop point onward.
- **Delivery, `valid` low or `valid && ready` on the same cycle:**
  - Load `out`, `frame_err` and `parity_err` from the shift register, `f_bad` and `p_bad`.
  - `valid` goes high (or stays high).
- **Delivery, `valid` high and `ready` low:**
  - The new word is dropped.
  - `overrun` goes high.
  - The held word and its flags are unchanged.
- **Handshake:** `valid && ready` with no delivery on that cycle → `valid` falls next cycle. `out` keeps its last value.
- **Clearing `overrun`:** only by `rst`, or by `en` going low.
- **`en` low mid-frame:** go to IDLE on the next edge and discard the partial frame. `valid`, `out` and the flags are untouched.
- **`rst`:**
  - `state` = IDLE, counter = 0.
  - Synchroniser and history = all ones.
  - `out` = 0; `valid`, `busy`, `frame_err`, `parity_err`, `overrun` = 0.

## Timing
- **Latency:** `valid` rises 3 + `HALF` + (`DATA_BITS` + P + `STOP_BITS`) × `OVERSAMPLE` clk edges after the first `clk` edge that samples `in` low. P = 1 if parity is compiled in, else 0.
  - Example: 16×, 8N1 → 155 edges.
- **Sampling position:** the majority window spans ticks `HALF-1` .. `HALF+1` of each bit, relative to the detected edge.
- **`busy`:** rises 1 edge after the synchronised low is seen. It falls on the edge where the state returns to IDLE.
- **Back-to-back frames:** a start edge arriving in the second half of the last stop bit is detected without loss.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - PARITY state exists.
  - `parity_err` reflects the comparison.
  - Frame length includes one parity bit.
- **`UART_RX_PARITY_EN` not defined:**
  - PARITY state and parity logic are omitted.
  - `parity_err` is tied to 0.
  - `PARITY_ODD` is ignored.

## Structure
- **Shared package `uart_pkg`:**
  - `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - Width helper constants.
  - Parity-sense constants `UART_PARITY_EVEN` and `UART_PARITY_ODD`, shared with the future parametrised transmitter.
- **Sub-module `uart_rx_sync`:** 2-flop synchroniser, 3-sample history and majority vote. Output is one majority bit. Reset to all ones.

## Test plan
- **Basic frame:** 16×, 8N1; send 0xA5 with `ready` tied high → `valid` pulses 1 cycle at edge 155, `out` = 0xA5, no error flags.
- **Parity:** `UART_RX_PARITY_EN`, `PARITY_ODD`=0; send 0x3C with a wrong parity bit → `out` = 0x3C, `parity_err` = 1, `frame_err` = 0.
- **Framing:** 8N1; send 0x55 with the stop bit held low → `valid`, `out` = 0x55, `frame_err` = 1.
- **Glitch rejection:**
  - A 4-tick low pulse on idle → no `valid`, `busy` returns low.
  - A single-tick inversion at a data-bit centre → the correct bit is still received.
- **Overrun:** `ready` = 0; send 0x11 then 0x22 back-to-back → `out` stays 0x11, `overrun` = 1. Raising `ready` → `valid` falls.
- **Mid-frame aborts:**
  - `en` deasserted at data bit 4 → `busy` = 0 and no `valid`.
  - The next frame, 0xF0, is received correctly.
  - `rst` asserted mid-frame → all outputs return to 0 immediately (asynchronous).
